// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, reset PC, fetch FSM states and the NOP word for the MIPS core.
package mips_pkg;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;
    typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bundle.
//   master (fetch stage): takes stall/flush/redirect/halt controls and imem_data;
//                         drives imem_addr, the IF/ID register outputs and status.
//   slave  (environment): the mirror image.
interface instruction_fetch_if;
    import mips_pkg::*;
    logic              stall;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              id_valid;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_plus4;
    logic              halted;
    logic              misaligned;
    logic [31:0]       fetch_count;
    modport master (
        input  stall, flush, redirect_valid, redirect_pc, halt, imem_data,
        output imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, halted, misaligned, fetch_count
    );
    modport slave (
        output stall, flush, redirect_valid, redirect_pc, halt, imem_data,
        input  imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, halted, misaligned, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_pc_next_mux.sv
// pc_next_mux: combinational next-PC selection.
//   pc, redirectValid, redirectPc, pendValid, pendPc -> nextPc, pcPlus4,
//   alignedTarget (redirectPc with [1:0] cleared), badTarget (redirect with nonzero [1:0]).
module pc_next_mux
    import mips_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirectValid,
    input  logic [ADDR_W-1:0] redirectPc,
    input  logic              pendValid,
    input  logic [ADDR_W-1:0] pendPc,
    output logic [ADDR_W-1:0] nextPc,
    output logic [ADDR_W-1:0] pcPlus4,
    output logic [ADDR_W-1:0] alignedTarget,
    output logic              badTarget
);
    always_comb begin
        pcPlus4       = pc + 32'd4;
        alignedTarget = {redirectPc[ADDR_W-1:2], 2'b00};
        badTarget     = redirectValid && (redirectPc[1:0] != 2'b00);
        nextPc        = redirectValid ? alignedTarget : pendValid ? pendPc : pcPlus4;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage; owns the PC, drives imem_addr, captures IF/ID.
//   clk, rst : clock and synchronous active-high reset
//   bus      : instruction_fetch_if.master (controls in, imem and IF/ID outputs)
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input logic               clk,
    input logic               rst,
    instruction_fetch_if.master bus
);
    fetch_state_t      state, nextState;
    logic [ADDR_W-1:0] pc, pendPc, nextPc, pcPlus4, alignedTarget, idPc, idPcPlus4;
    logic [INST_W-1:0] idInst;
    logic [31:0]       fetchCount;
    logic              pendValid, badTarget, idValid, misSticky, running;

    pc_next_mux u_mux (
        .pc(pc),
        .redirectValid(bus.redirect_valid),
        .redirectPc(bus.redirect_pc),
        .pendValid(pendValid),
        .pendPc(pendPc),
        .nextPc(nextPc),
        .pcPlus4(pcPlus4),
        .alignedTarget(alignedTarget),
        .badTarget(badTarget)
    );

    always_comb begin
        running   = state == RUN;
        nextState = state;
        if (running && !bus.stall && bus.halt)
            nextState = HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            pendValid  <= 1'b0;
            pendPc     <= '0;
            idValid    <= 1'b0;
            idInst     <= NOP;
            idPc       <= '0;
            idPcPlus4  <= '0;
            misSticky  <= 1'b0;
            fetchCount <= '0;
        end else begin
            state     <= nextState;
            misSticky <= misSticky | (running && badTarget);
            if (!running)
                idValid <= 1'b0;
            else if (bus.stall) begin
                // Park the redirect until the stall releases; a newer one wins.
                if (bus.redirect_valid) begin
                    pendValid <= 1'b1;
                    pendPc    <= alignedTarget;
                end
                if (bus.flush)
                    idValid <= 1'b0;
            end else begin
                pc         <= nextPc;
                pendValid  <= 1'b0;
                idInst     <= bus.imem_data;
                idPc       <= pc;
                idPcPlus4  <= pcPlus4;
                idValid    <= !bus.flush;
                fetchCount <= fetchCount + {31'b0, !bus.flush};
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.id_valid    = idValid;
    assign bus.id_inst     = idInst;
    assign bus.id_pc       = idPc;
    assign bus.id_pc_plus4 = idPcPlus4;
    assign bus.halted      = state == HALTED;
    assign bus.misaligned  = misSticky;
    assign bus.fetch_count = fetchCount;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with directed scenarios and random traffic.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();
    instruction_fetch #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h2008_0001 + (a >> 2) * 32'h0001_0001;
    endfunction

    assign bus.imem_data = memWord(bus.imem_addr);

    typedef struct {
        logic [31:0] addr, inst, pc, pc4, cnt;
        logic        valid, halted, mis;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    logic [31:0] mPc, mPendPc, mInst, mIdPc, mIdPc4, mCnt;
    logic        mPendV, mHalted, mValid, mMis;

    task automatic step(input logic r, input logic st, input logic fl,
                        input logic rv, input logic [31:0] rpc, input logic h);
        exp_t e;
        @(negedge clk);
        rst = r; bus.stall = st; bus.flush = fl; bus.redirect_valid = rv;
        bus.redirect_pc = rpc; bus.halt = h;
        if (r) begin
            mPc = 0; mPendV = 0; mPendPc = 0; mHalted = 0; mValid = 0;
            mInst = 0; mIdPc = 0; mIdPc4 = 0; mMis = 0; mCnt = 0;
        end else if (mHalted) begin
            mValid = 0;
        end else if (st) begin
            if (rv) begin
                mPendV = 1; mPendPc = rpc & 32'hFFFF_FFFC;
                if (rpc % 4 != 0) mMis = 1;
            end
            if (fl) mValid = 0;
        end else begin
            mInst = memWord(mPc); mIdPc = mPc; mIdPc4 = mPc + 4;
            mValid = !fl;
            if (!fl) mCnt = mCnt + 1;
            if (rv) begin
                mPc = rpc & 32'hFFFF_FFFC;
                if (rpc % 4 != 0) mMis = 1;
            end else if (mPendV) mPc = mPendPc;
            else mPc = mPc + 4;
            mPendV = 0;
            if (h) mHalted = 1;
        end
        e.addr = mPc; e.inst = mInst; e.pc = mIdPc; e.pc4 = mIdPc4; e.cnt = mCnt;
        e.valid = mValid; e.halted = mHalted; e.mis = mMis;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic runTo(input logic [31:0] target);
        for (int i = 0; i < 64 && mPc != target; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("imem_addr", bus.imem_addr, e.addr);
            cmp("id_valid", {31'b0, bus.id_valid}, {31'b0, e.valid});
            cmp("id_inst", bus.id_inst, e.inst);
            cmp("id_pc", bus.id_pc, e.pc);
            cmp("id_pc_plus4", bus.id_pc_plus4, e.pc4);
            cmp("halted", {31'b0, bus.halted}, {31'b0, e.halted});
            cmp("misaligned", {31'b0, bus.misaligned}, {31'b0, e.mis});
            cmp("fetch_count", bus.fetch_count, e.cnt);
        end
    end

    initial begin
        bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.halt = 0;
        // reset and sequential fetch
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(3);
        // redirect with delay slot
        step(1, 0, 0, 0, 0, 0);
        runTo(32'h8);
        step(0, 0, 0, 1, 32'h40, 0);
        idle(2);
        // redirect during stall
        step(1, 0, 0, 0, 0, 0);
        runTo(32'h10);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 32'h80, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(2);
        // flush alone, then flush with stall
        step(1, 0, 0, 0, 0, 0);
        runTo(32'h24);
        step(0, 0, 1, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 0, 0, 0);
        idle(1);
        // halt
        step(1, 0, 0, 0, 0, 0);
        runTo(32'h30);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 0, 1, 32'h100, 0);
        step(0, 1, 1, 1, 32'h200, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        // misalignment and wrap
        step(0, 0, 0, 1, 32'h43, 0);
        idle(1);
        step(0, 0, 0, 1, 32'h80, 0);
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        idle(2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom_range(0, 32'h3FF);
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0, rpc, $urandom_range(0, 59) == 0);
        end
        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
